// File: rtl/romix_pkg.sv
// -----------------------------------------------------------------------------
// romix_pkg
//   Shared constants for the ROMix front-end loader:
//     ROMIX_WORD_W / ROMIX_BLOCK_W / ROMIX_KEY_W : stream word, block B and
//       HMAC state widths
//     ROMIX_NWORDS / ROMIX_CNT_W                  : words per job and counter width
//     IXOR_BASE / OXOR_BASE / BLOCK_BASE          : word offset of each field
//                                                   inside a job
//     loader_state_t                              : loader FSM encoding
//     bswap32()                                   : byte reversal, big-endian
//                                                   SHA-256 word to
//                                                   little-endian Salsa20 word
// -----------------------------------------------------------------------------
package romix_pkg;

  localparam int ROMIX_WORD_W  = 32;
  localparam int ROMIX_BLOCK_W = 1024;
  localparam int ROMIX_KEY_W   = 256;
  localparam int ROMIX_NWORDS  = 2 * ROMIX_KEY_W / ROMIX_WORD_W + ROMIX_BLOCK_W / ROMIX_WORD_W;
  localparam int ROMIX_CNT_W   = $clog2(ROMIX_NWORDS);

  localparam int IXOR_BASE  = 0;
  localparam int OXOR_BASE  = ROMIX_KEY_W / ROMIX_WORD_W;
  localparam int BLOCK_BASE = 2 * ROMIX_KEY_W / ROMIX_WORD_W;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FULL   = 2'd1,
    ST_RESYNC = 2'd2
  } loader_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/romix_job_loader.sv
// -----------------------------------------------------------------------------
// romix_job_loader
//   Collects a 32-bit word stream from the PBKDF2-SHA256 front end into one
//   ROMix job (ixor w0..w7, oxor w0..w7, block B w0..w31) and presents it as a
//   single parallel word with a valid/ready handshake.
//
//   Build option: ROMIX_LOADER_BSWAP_EN -- when defined, every accepted word is
//   byte-reversed before storage (SHA-256 big-endian to Salsa20 little-endian).
//   Latency and control behaviour are identical either way.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   s_data   in   stream word
//   s_valid  in   s_data valid
//   s_last   in   final word of a job
//   s_ready  out  loader accepts a word this cycle
//   m_valid  out  complete job held on m_*
//   m_ready  in   ROMix controller consumes the job
//   m_ixor   out  inner HMAC state
//   m_oxor   out  outer HMAC state
//   m_block  out  block B
//   err_len  out  one-cycle pulse on a job length error
//   busy     out  a job is partly loaded or waiting for hand-off
// -----------------------------------------------------------------------------
module romix_job_loader
  import romix_pkg::*;
#(
  parameter int WORD_W  = ROMIX_WORD_W,
  parameter int BLOCK_W = ROMIX_BLOCK_W,
  parameter int KEY_W   = ROMIX_KEY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [KEY_W-1:0]   m_ixor,
  output logic [KEY_W-1:0]   m_oxor,
  output logic [BLOCK_W-1:0] m_block,
  output logic               err_len,
  output logic               busy
);

  localparam int KWORDS   = KEY_W / WORD_W;
  localparam int BWORDS   = BLOCK_W / WORD_W;
  localparam int NWORDS   = 2 * KWORDS + BWORDS;
  localparam int CNT_W    = $clog2(NWORDS);
  localparam int OXOR_OFS = KWORDS;
  localparam int BLK_OFS  = 2 * KWORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] words [NWORDS];
  logic [WORD_W-1:0] wr_word;
  logic              accept;
  logic              at_last;

  assign accept  = s_valid & s_ready;
  assign at_last = (cnt == LAST_IDX);

  always_comb begin
`ifdef ROMIX_LOADER_BSWAP_EN
    wr_word = bswap32(s_data);
`else
    wr_word = s_data;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_LOAD;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        // Reaching the 48th word decides: a proper end of job, or an
        // overlong job whose tail must be skipped up to its s_last.
        if (accept && at_last) state_nxt = s_last ? ST_FULL : ST_RESYNC;
      end
      ST_FULL: begin
        if (m_ready) state_nxt = ST_LOAD;
      end
      ST_RESYNC: begin
        if (accept && s_last) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_LOAD:   busy = (cnt != '0);
      ST_FULL: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // Word counter and length-error pulse. A length error is s_last arriving
  // anywhere other than the final word slot, or the final slot without s_last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= (state == ST_LOAD) && accept && (s_last != at_last);
      if (state == ST_LOAD && accept) begin
        if (s_last || at_last) cnt <= '0;
        else                   cnt <= cnt + 1'b1;
      end else if (state == ST_FULL && m_ready) begin
        cnt <= '0;
      end
    end
  end

  // Word-indexed write decoder; registers are only overwritten, never cleared
  // between jobs, since every slot is rewritten before the next m_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NWORDS; i++) words[i] <= '0;
    end else if (state == ST_LOAD && accept) begin
      words[cnt] <= wr_word;
    end
  end

  for (genvar k = 0; k < KWORDS; k++) begin : g_key
    assign m_ixor[WORD_W*k +: WORD_W] = words[IXOR_BASE + k];
    assign m_oxor[WORD_W*k +: WORD_W] = words[OXOR_OFS + k];
  end

  for (genvar k = 0; k < BWORDS; k++) begin : g_blk
    assign m_block[WORD_W*k +: WORD_W] = words[BLK_OFS + k];
  end

endmodule

// File: tb/tb_romix_job_loader.sv
module tb_romix_job_loader;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic          m_ready;
  logic [255:0]  m_ixor;
  logic [255:0]  m_oxor;
  logic [1023:0] m_block;
  logic          err_len;
  logic          busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  romix_job_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_ixor  (m_ixor),
    .m_oxor  (m_oxor),
    .m_block (m_block),
    .err_len (err_len),
    .busy    (busy)
  );

  typedef struct {
    int          field;  // 0 ixor, 1 oxor, 2 block
    int          k;      // word index within the field
    logic [31:0] off;    // stream position of that word
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef ROMIX_LOADER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] get_word(input int field, input int k);
    case (field)
      0:       return m_ixor[32*k +: 32];
      1:       return m_oxor[32*k +: 32];
      default: return m_block[32*k +: 32];
    endcase
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_range(input logic [31:0] base, input int from, input int to, input int last_idx);
    for (int i = from; i <= to; i++) send_word(base + 32'(i), i == last_idx);
  endtask

  task automatic check_job(input logic [31:0] base, input string tag);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s_f%0d_w%0d", tag, vecs[i].field, vecs[i].k),
            64'(get_word(vecs[i].field, vecs[i].k)), 64'(exp_word(base + vecs[i].off)));
  endtask

  task automatic handoff(input string tag);
    check({tag, "_mvalid_before"}, 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, "_mvalid_after"}, 64'(m_valid), 64'd0);
    check({tag, "_sready_after"}, 64'(s_ready), 64'd1);
    check({tag, "_busy_after"},   64'(busy),    64'd0);
  endtask

  initial begin
    logic [1023:0] blk_snap;
    logic [255:0]  ix_snap;
    logic [255:0]  ox_snap;
    int            n;
    int            cyc;
    logic          v;

    vecs[0] = '{0, 0,  32'd0};
    vecs[1] = '{0, 7,  32'd7};
    vecs[2] = '{1, 0,  32'd8};
    vecs[3] = '{1, 7,  32'd15};
    vecs[4] = '{2, 0,  32'd16};
    vecs[5] = '{2, 15, 32'd31};
    vecs[6] = '{2, 31, 32'd47};

    reset_n = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mvalid", 64'(m_valid), 64'd0);
    check("rst_err",    64'(err_len), 64'd0);
    check("rst_busy",   64'(busy),    64'd0);
    check("rst_block0", 64'(m_block == '0), 64'd1);
    check("rst_ixor0",  64'(m_ixor == '0),  64'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sready", 64'(s_ready), 64'd1);

    // Basic 48-word job, hand-off held off afterwards
    send_word(32'hA5A50000, 1'b0);
    check("t1_busy_first", 64'(busy), 64'd1);
    send_range(32'hA5A50000, 1, 46, 47);
    check("t1_mvalid_early", 64'(m_valid), 64'd0);
    send_word(32'hA5A5002F, 1'b1);
    check("t1_mvalid",  64'(m_valid), 64'd1);
    check("t1_sready",  64'(s_ready), 64'd0);
    check("t1_err",     64'(err_len), 64'd0);
    check_job(32'hA5A50000, "t1");

    // Back-pressure: stall 20 cycles, stream inputs must be ignored
    blk_snap = m_block;
    ix_snap  = m_ixor;
    ox_snap  = m_oxor;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1;
      s_data  = 32'hDEAD0000 + 32'(c);
      s_last  = c[0];
      @(posedge clk);
      #1;
      check($sformatf("t2_sready_c%0d", c), 64'(s_ready), 64'd0);
      check($sformatf("t2_hold_c%0d", c),
            64'(m_valid && !err_len && m_block == blk_snap && m_ixor == ix_snap && m_oxor == ox_snap),
            64'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    handoff("t2");

    // Short job: s_last on word 10
    send_range(32'hB1B10000, 0, 10, 10);
    check("t3_err",    64'(err_len), 64'd1);
    check("t3_mvalid", 64'(m_valid), 64'd0);
    check("t3_busy",   64'(busy),    64'd0);
    @(posedge clk);
    #1;
    check("t3_err_pulse", 64'(err_len), 64'd0);
    send_range(32'hB2B20000, 0, 47, 47);
    check("t3_next_mvalid", 64'(m_valid), 64'd1);
    check_job(32'hB2B20000, "t3");
    handoff("t3");

    // Long job: 50 words, s_last on word 49
    send_range(32'hC1C10000, 0, 47, 49);
    check("t4_err",    64'(err_len), 64'd1);
    check("t4_mvalid", 64'(m_valid), 64'd0);
    send_word(32'hC1C10030, 1'b0);
    check("t4_err_pulse", 64'(err_len), 64'd0);
    check("t4_sready48",  64'(s_ready), 64'd1);
    check("t4_mvalid48",  64'(m_valid), 64'd0);
    send_word(32'hC1C10031, 1'b1);
    check("t4_mvalid49", 64'(m_valid), 64'd0);
    check("t4_err49",    64'(err_len), 64'd0);
    send_range(32'hC2C20000, 0, 47, 47);
    check("t4_next_mvalid", 64'(m_valid), 64'd1);
    check_job(32'hC2C20000, "t4");
    handoff("t4");

    // Gappy s_valid during a job
    n   = 0;
    cyc = 0;
    while (n < 48 && cyc < 2000) begin
      v       = 1'($urandom_range(0, 1));
      s_valid = v;
      s_data  = v ? (32'hD1D10000 + 32'(n)) : $urandom;
      s_last  = (n == 47) || (!v && $urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
      if (v) n++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t5_words_sent", 64'(n), 64'd48);
    check("t5_mvalid", 64'(m_valid), 64'd1);
    check_job(32'hD1D10000, "t5");
    handoff("t5");

    // Reset in the middle of the next job
    send_range(32'hD2D20000, 0, 29, 47);
    check("t5_busy_mid", 64'(busy), 64'd1);
    s_valid = 1'b1;
    s_data  = 32'hD2D2001E;
    reset_n = 1'b0;
    #2;
    check("t5r_mvalid", 64'(m_valid), 64'd0);
    check("t5r_busy",   64'(busy),    64'd0);
    check("t5r_err",    64'(err_len), 64'd0);
    check("t5r_block0", 64'(m_block == '0), 64'd1);
    check("t5r_ixor0",  64'(m_ixor == '0),  64'd1);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5r_sready", 64'(s_ready), 64'd1);
    check("t5r_err2",   64'(err_len), 64'd0);
    send_range(32'hE0E00000, 0, 47, 47);
    check("t5r_next_mvalid", 64'(m_valid), 64'd1);
    check_job(32'hE0E00000, "t5r");
    handoff("t5r");

    // Byte order of stored words
    send_word(32'h11223344, 1'b0);
    send_range(32'hF0F00000, 1, 47, 47);
    check("t6_mvalid", 64'(m_valid), 64'd1);
    check("t6_ixor_w0", 64'(m_ixor[31:0]),  64'(exp_word(32'h11223344)));
    check("t6_ixor_w1", 64'(m_ixor[63:32]), 64'(exp_word(32'hF0F00001)));
    handoff("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
